// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side bundle for sync_fifo_param: requests in, data and status out.
// The FIFO takes the slave modport; the block driving it takes master.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              clr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wen, wdata, ren,
        input  rdata, rvalid, count, full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  clr, wen, wdata, ren,
        output rdata, rvalid, count, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with overwrite/drop-on-full, almost thresholds,
// registered read data with a valid strobe, sticky overflow/underflow and synchronous flush.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned OVERWRITE = 1,
    parameter int unsigned AF_TH     = DEPTH - 2,
    parameter int unsigned AE_TH     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_param_if.slave   bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfThC  = CW'(AF_TH);
    localparam logic [CW-1:0] AeThC  = CW'(AE_TH);
    localparam bit OverwriteEn = (OVERWRITE != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic is_full, is_empty;
    logic wr_ok, rd_ok, drop_oldest;

    assign is_full  = (count_q == DepthC);
    assign is_empty = (count_q == '0);

    always_comb begin
        rd_ok       = 1'b0;
        wr_ok       = 1'b0;
        drop_oldest = 1'b0;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;

        if (bus_io.clr) begin
            waddr_d = '0;
            raddr_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            rd_ok = bus_io.ren && !is_empty;
            // A full write with no read either evicts the oldest entry or is dropped.
            drop_oldest = bus_io.wen && is_full && !bus_io.ren && OverwriteEn;
            wr_ok = bus_io.wen && (!is_full || rd_ok || drop_oldest);

            if (bus_io.ren && is_empty) unf_d = 1'b1;
            if (bus_io.wen && is_full && !bus_io.ren) ovf_d = 1'b1;

            if (wr_ok) waddr_d = waddr_q + 1'b1;
            if (rd_ok || drop_oldest) raddr_d = raddr_q + 1'b1;
            if (rd_ok) begin
                rdata_d  = mem_q[raddr_q];
                rvalid_d = 1'b1;
            end

            if (wr_ok && !rd_ok && !drop_oldest) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[waddr_q] <= bus_io.wdata;
    end

    assign bus_io.rdata        = rdata_q;
    assign bus_io.rvalid       = rvalid_q;
    assign bus_io.count        = count_q;
    assign bus_io.full         = rst_n && is_full;
    assign bus_io.empty        = rst_n && is_empty;
    assign bus_io.almost_full  = rst_n && (count_q >= AfThC);
    assign bus_io.almost_empty = rst_n && (count_q <= AeThC);
    assign bus_io.overflow     = ovf_q;
    assign bus_io.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives an overwrite-mode and a drop-mode FIFO with identical stimulus and checks
// both against a queue-based reference model after every clock.
module tb_sync_fifo_param;
    localparam int unsigned DW = 8;
    localparam int unsigned DP = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr   = 1'b0;
    logic          wen   = 1'b0;
    logic          ren   = 1'b0;
    logic [DW-1:0] wdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if_ovw ();
    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if_drop ();

    assign if_ovw.clr    = clr;
    assign if_ovw.wen    = wen;
    assign if_ovw.wdata  = wdata;
    assign if_ovw.ren    = ren;
    assign if_drop.clr   = clr;
    assign if_drop.wen   = wen;
    assign if_drop.wdata = wdata;
    assign if_drop.ren   = ren;

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .OVERWRITE(1), .AF_TH(DP - 2), .AE_TH(2)
    ) u_dut_ovw (
        .clk(clk), .rst_n(rst_n), .bus_io(if_ovw.slave)
    );

    sync_fifo_param #(
        .DATA_W(DW), .DEPTH(DP), .OVERWRITE(0), .AF_TH(DP - 2), .AE_TH(2)
    ) u_dut_drop (
        .clk(clk), .rst_n(rst_n), .bus_io(if_drop.slave)
    );

    // Reference model: index 0 overwrites when full, index 1 drops.
    logic [DW-1:0] mq [2][$];
    logic          ovf_m [2];
    logic          unf_m [2];
    logic          rv_m  [2];
    logic [DW-1:0] rd_m  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            ovf_m[i] = 1'b0;
            unf_m[i] = 1'b0;
            rv_m[i]  = 1'b0;
            rd_m[i]  = '0;
        end
    endtask

    task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        for (int i = 0; i < 2; i++) begin
            int n;
            n = mq[i].size();
            rv_m[i] = 1'b0;
            if (c) begin
                mq[i].delete();
                ovf_m[i] = 1'b0;
                unf_m[i] = 1'b0;
            end else if (w && n == int'(DP) && !r) begin
                ovf_m[i] = 1'b1;
                if (i == 0) begin
                    void'(mq[i].pop_front());
                    mq[i].push_back(d);
                end
            end else begin
                if (r && n == 0) unf_m[i] = 1'b1;
                if (r && n > 0) begin
                    rd_m[i] = mq[i].pop_front();
                    rv_m[i] = 1'b1;
                end
                if (w) mq[i].push_back(d);
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [4:0] cnt, input logic fl, input logic em,
                             input logic af, input logic ae, input logic ov, input logic un,
                             input logic rv, input logic [DW-1:0] rd);
        int    n;
        string p;
        n = mq[i].size();
        p = (i == 0) ? "ovw" : "drop";
        check_eq({p, ".count"}, 32'(cnt), 32'(n));
        check_eq({p, ".full"}, 32'(fl), 32'(rst_n && n == int'(DP)));
        check_eq({p, ".empty"}, 32'(em), 32'(rst_n && n == 0));
        check_eq({p, ".almost_full"}, 32'(af), 32'(rst_n && n >= int'(DP) - 2));
        check_eq({p, ".almost_empty"}, 32'(ae), 32'(rst_n && n <= 2));
        check_eq({p, ".overflow"}, 32'(ov), 32'(ovf_m[i]));
        check_eq({p, ".underflow"}, 32'(un), 32'(unf_m[i]));
        check_eq({p, ".rvalid"}, 32'(rv), 32'(rv_m[i]));
        check_eq({p, ".rdata"}, 32'(rd), 32'(rd_m[i]));
    endtask

    task automatic check_all();
        check_dut(0, if_ovw.count, if_ovw.full, if_ovw.empty, if_ovw.almost_full,
                  if_ovw.almost_empty, if_ovw.overflow, if_ovw.underflow, if_ovw.rvalid,
                  if_ovw.rdata);
        check_dut(1, if_drop.count, if_drop.full, if_drop.empty, if_drop.almost_full,
                  if_drop.almost_empty, if_drop.overflow, if_drop.underflow, if_drop.rvalid,
                  if_drop.rdata);
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wen   = w;
        wdata = d;
        ren   = r;
        clr   = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
        check_all();
    endtask

    initial begin
        logic          w, r, c;
        logic [DW-1:0] d;

        model_reset();
        #3;
        check_all();
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Fill past full, then drain: overwrite keeps 0x02..0x11, drop keeps 0x01..0x10.
        for (int k = 1; k <= 17; k++) step(1'b1, DW'(k), 1'b0, 1'b0);
        for (int k = 0; k < 17; k++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Underflow, then simultaneous write+read on empty, then read that entry back.
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Streaming at count 5 across pointer wrap, flushed mid-stream.
        for (int k = 0; k < 5; k++) step(1'b1, DW'(8'h30 + k), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, DW'($urandom_range(0, 255)), 1'b1, k == 25);
        end
        step(1'b0, '0, 1'b0, 1'b0);

        // Random traffic: write-heavy first half, read-heavy second half.
        for (int k = 0; k < 400; k++) begin
            w = ($urandom_range(0, 99) < ((k < 200) ? 75 : 30));
            r = ($urandom_range(0, 99) < ((k < 200) ? 30 : 75));
            c = ($urandom_range(0, 79) == 0);
            d = DW'($urandom_range(0, 255));
            step(w, d, r, c);
        end

        // Asynchronous reset between edges at count 9.
        step(1'b0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) step(1'b1, DW'(8'h50 + k), 1'b0, 1'b0);
        step(1'b1, 8'h59, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, DW'(8'h70 + k), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
